// File: rtl/execute_pkg.sv
// Shared LC-3 Execute-stage definitions: opcodes, ALU/address-select encodings
// and the Decode-to-Execute control bundle layout.
package execute_pkg;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_AND  = 2'b01,
      ALU_NOT  = 2'b10,
      ALU_RSVD = 2'b11
   } alu_control_t;

   localparam logic [1:0] PCSEL1_OFF11 = 2'b00;
   localparam logic [1:0] PCSEL1_OFF9  = 2'b01;
   localparam logic [1:0] PCSEL1_OFF6  = 2'b10;
   localparam logic [1:0] PCSEL1_ZERO  = 2'b11;

   typedef struct packed {
      alu_control_t alu_control;
      logic [1:0]   pcselect1;
      logic         pcselect2;
      logic         op2select;
   } e_control_t;

endpackage

// File: rtl/execute_if.sv
// Decode/bypass bundle into Execute and the registered results it hands on.
interface execute_if;
   logic        enable_execute;
   logic [15:0] IR;
   logic [5:0]  E_Control;
   logic [15:0] npc_in;
   logic        Mem_Control_in;
   logic [1:0]  W_Control_in;
   logic [15:0] VSR1;
   logic [15:0] VSR2;
   logic        bypass_alu_1;
   logic        bypass_alu_2;
   logic        bypass_mem_1;
   logic        bypass_mem_2;
   logic [15:0] Mem_Bypass_Val;
   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic [15:0] aluout;
   logic [15:0] pcout;
   logic [15:0] M_Data;
   logic [2:0]  dr;
   logic [2:0]  NZP;
   logic [15:0] IR_Exec;
   logic [1:0]  W_Control_out;
   logic        Mem_Control_out;

   modport master (
      output enable_execute, IR, E_Control, npc_in, Mem_Control_in, W_Control_in,
             VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
             Mem_Bypass_Val,
      input  sr1, sr2, aluout, pcout, M_Data, dr, NZP, IR_Exec, W_Control_out,
             Mem_Control_out
   );

   modport slave (
      input  enable_execute, IR, E_Control, npc_in, Mem_Control_in, W_Control_in,
             VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
             Mem_Bypass_Val,
      output sr1, sr2, aluout, pcout, M_Data, dr, NZP, IR_Exec, W_Control_out,
             Mem_Control_out
   );
endinterface

// File: rtl/execute_addr_gen.sv
// Address adder: selects PC-relative or register base and adds a
// sign-extended IR offset, wrapping modulo 2^16.
module execute_addr_gen
   import execute_pkg::*;
(
   input  logic [10:0] ir_off,
   input  logic [15:0] npc,
   input  logic [15:0] op1,
   input  logic [1:0]  pcselect1,
   input  logic        pcselect2,
   output logic [15:0] addr
);
   logic [15:0] base;
   logic [15:0] offset;

   always_comb begin
      base = pcselect2 ? npc : op1;
      case (pcselect1)
         PCSEL1_OFF11: offset = {{5{ir_off[10]}}, ir_off[10:0]};
         PCSEL1_OFF9:  offset = {{7{ir_off[8]}},  ir_off[8:0]};
         PCSEL1_OFF6:  offset = {{10{ir_off[5]}}, ir_off[5:0]};
         PCSEL1_ZERO:  offset = '0;
         default:      offset = '0;
      endcase
      addr = base + offset;
   end
endmodule

// File: rtl/execute.sv
// LC-3 Execute stage: operand bypass, ALU, address generation and the
// registered hand-off to Memory/Writeback.
module execute
   import execute_pkg::*;
(
   input logic      clock,
   input logic      reset,
   execute_if.slave bus
);
   e_control_t  ectl;
   logic [3:0]  opcode;
   logic        is_store;
   logic        is_alu_op;
   logic        writes_dr;
   logic [15:0] op1;
   logic [15:0] op2;
   logic [15:0] alu_b;
   logic [15:0] alu_res;
   logic [15:0] addr;

   assign ectl      = e_control_t'(bus.E_Control);
   assign opcode    = bus.IR[15:12];
   assign is_store  = opcode inside {OP_ST, OP_STR, OP_STI};
   assign is_alu_op = opcode inside {OP_ADD, OP_AND, OP_NOT};
   assign writes_dr = opcode inside {OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI, OP_LEA};

   assign bus.sr1 = bus.IR[8:6];
   assign bus.sr2 = is_store ? bus.IR[11:9] : bus.IR[2:0];

   // ALU bypass outranks memory bypass: the aluout register is the younger result
   always_comb begin
      if (bus.bypass_alu_1)      op1 = bus.aluout;
      else if (bus.bypass_mem_1) op1 = bus.Mem_Bypass_Val;
      else                       op1 = bus.VSR1;
      if (bus.bypass_alu_2)      op2 = bus.aluout;
      else if (bus.bypass_mem_2) op2 = bus.Mem_Bypass_Val;
      else                       op2 = bus.VSR2;
   end

   always_comb begin
      alu_b = ectl.op2select ? op2 : {{11{bus.IR[4]}}, bus.IR[4:0]};
      case (ectl.alu_control)
         ALU_ADD:  alu_res = op1 + alu_b;
         ALU_AND:  alu_res = op1 & alu_b;
         ALU_NOT:  alu_res = ~op1;
         ALU_RSVD: alu_res = '0;
         default:  alu_res = '0;
      endcase
   end

   execute_addr_gen u_addr_gen (
      .ir_off    (bus.IR[10:0]),
      .npc       (bus.npc_in),
      .op1       (op1),
      .pcselect1 (ectl.pcselect1),
      .pcselect2 (ectl.pcselect2),
      .addr      (addr)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         bus.aluout          <= '0;
         bus.pcout           <= '0;
         bus.M_Data          <= '0;
         bus.dr              <= '0;
         bus.NZP             <= '0;
         bus.IR_Exec         <= '0;
         bus.W_Control_out   <= '0;
         bus.Mem_Control_out <= '0;
      end else if (bus.enable_execute) begin
         bus.aluout          <= is_alu_op ? alu_res : addr;
         bus.pcout           <= addr;
         bus.M_Data          <= is_store ? op2 : '0;
         bus.dr              <= writes_dr ? bus.IR[11:9] : '0;
         bus.NZP             <= (opcode == OP_BR)  ? bus.IR[11:9] :
                                (opcode == OP_JMP) ? 3'b111 : 3'b000;
         bus.IR_Exec         <= bus.IR;
         bus.W_Control_out   <= bus.W_Control_in;
         bus.Mem_Control_out <= bus.Mem_Control_in;
      end
   end
endmodule
